// File: rtl/rsv_station_pip0_if.sv
// Bundle of decode, writeback and scoreboard-facing signals for the pip0 reservation station.
// Carries the occupancy output only when RSV_PIP0_OCC_EN is defined.
interface rsv_station_pip0_if #(
    parameter int unsigned W_PA_REG     = 5,
    parameter int unsigned W_PD_UOPS    = 6,
    parameter int unsigned W_PC_SEL_RSV = 2,
    parameter int unsigned W_PC_SEL_WB  = 2,
    parameter int unsigned W_PC_SEL_ODR = 2,
    parameter int unsigned W_ent_idx    = 2
);
    logic                    CFI_PC_clear;
    logic                    CFI_PC_valid_in;
    logic                    CFO_PC_full;
    logic [W_PD_UOPS-1:0]    CDI_PD_uops_in;
    logic [W_PA_REG-1:0]     CDI_PD_rd_in;
    logic [W_PA_REG-1:0]     CDI_PA_rs1_in;
    logic [W_PA_REG-1:0]     CDI_PA_rs2_in;
    logic                    CDI_PC_rs1_rdy;
    logic                    CDI_PC_rs2_rdy;
    logic [W_PA_REG-1:0]     CDI_PC_wb_rd;
    logic [W_PC_SEL_WB-1:0]  CDI_PC_wb_sel;
    logic [W_PD_UOPS-1:0]    CDO_PD_uops0;
    logic [W_PA_REG-1:0]     CDO_PD_rd0;
    logic [W_PD_UOPS-1:0]    CDO_PD_uops1;
    logic [W_PA_REG-1:0]     CDO_PD_rd1;
    logic [W_PC_SEL_ODR-1:0] CDO_PC_odr;
    logic [W_PC_SEL_RSV-1:0] CDI_PC_selrsv;
`ifdef RSV_PIP0_OCC_EN
    logic [W_ent_idx:0]      CDO_PC_occ;
`endif

    modport master (
        output CFI_PC_clear, CFI_PC_valid_in, CDI_PD_uops_in, CDI_PD_rd_in,
               CDI_PA_rs1_in, CDI_PA_rs2_in, CDI_PC_rs1_rdy, CDI_PC_rs2_rdy,
               CDI_PC_wb_rd, CDI_PC_wb_sel, CDI_PC_selrsv,
        input  CFO_PC_full, CDO_PD_uops0, CDO_PD_rd0, CDO_PD_uops1, CDO_PD_rd1, CDO_PC_odr
`ifdef RSV_PIP0_OCC_EN
        , input CDO_PC_occ
`endif
    );

    modport slave (
        input  CFI_PC_clear, CFI_PC_valid_in, CDI_PD_uops_in, CDI_PD_rd_in,
               CDI_PA_rs1_in, CDI_PA_rs2_in, CDI_PC_rs1_rdy, CDI_PC_rs2_rdy,
               CDI_PC_wb_rd, CDI_PC_wb_sel, CDI_PC_selrsv,
        output CFO_PC_full, CDO_PD_uops0, CDO_PD_rd0, CDO_PD_uops1, CDO_PD_rd1, CDO_PC_odr
`ifdef RSV_PIP0_OCC_EN
        , output CDO_PC_occ
`endif
    );
endinterface

// File: rtl/rsv_station_pip0.sv
// Dual-pipe (ALU pip0 / MUL pip1) age-ordered compacting reservation station with writeback wakeup.
// Optional occupancy output enabled by defining RSV_PIP0_OCC_EN.
module rsv_station_pip0 #(
    parameter int unsigned W_PA_REG     = 5,
    parameter int unsigned W_PD_UOPS    = 6,
    parameter int unsigned W_PC_SEL_RSV = 2,
    parameter int unsigned W_PC_SEL_WB  = 2,
    parameter int unsigned W_PC_SEL_ODR = 2,
    parameter int unsigned S_amt_ent    = 4,
    parameter int unsigned W_ent_idx    = 2
) (
    input logic             clk,
    input logic             rst,
    rsv_station_pip0_if.slave bus
);
    localparam logic [W_PD_UOPS-1:0]    unused_op = {W_PD_UOPS{1'b1}};
    localparam logic [W_PC_SEL_WB-1:0]  V_unpip   = '0;
    localparam logic [W_PC_SEL_RSV-1:0] V_pip0    = W_PC_SEL_RSV'(1);
    localparam logic [W_PC_SEL_RSV-1:0] V_pip1    = W_PC_SEL_RSV'(2);
    localparam logic [W_PC_SEL_ODR-1:0] V_odrf0   = W_PC_SEL_ODR'(1);
    localparam logic [W_PC_SEL_ODR-1:0] V_odrf1   = W_PC_SEL_ODR'(2);

    logic [S_amt_ent-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d, wake1, wake2;
    logic [W_PD_UOPS-1:0] uops_q [S_amt_ent];
    logic [W_PD_UOPS-1:0] uops_d [S_amt_ent];
    logic [W_PA_REG-1:0]  rd_q   [S_amt_ent];
    logic [W_PA_REG-1:0]  rd_d   [S_amt_ent];
    logic [W_PA_REG-1:0]  rs1_q  [S_amt_ent];
    logic [W_PA_REG-1:0]  rs1_d  [S_amt_ent];
    logic [W_PA_REG-1:0]  rs2_q  [S_amt_ent];
    logic [W_PA_REG-1:0]  rs2_d  [S_amt_ent];

    logic                    alu_hit, mul_hit, pop_en, push_ok, wb_vld, full, rdy1_in, rdy2_in;
    logic [W_ent_idx-1:0]    alu_idx, mul_idx, pop_idx, push_idx;
    logic [W_ent_idx:0]      cnt;
    logic [W_PC_SEL_ODR-1:0] odr;

    // Oldest ready entry per class; descending scan lets the lowest index win.
    always_comb begin
        alu_hit = 1'b0;
        mul_hit = 1'b0;
        alu_idx = '0;
        mul_idx = '0;
        cnt     = '0;
        for (int i = S_amt_ent - 1; i >= 0; i--) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                if (uops_q[i][W_PD_UOPS-1]) begin
                    mul_hit = 1'b1;
                    mul_idx = W_ent_idx'(i);
                end else begin
                    alu_hit = 1'b1;
                    alu_idx = W_ent_idx'(i);
                end
            end
            cnt = cnt + (W_ent_idx + 1)'(valid_q[i]);
        end
    end

    always_comb begin
        odr = '0;
        if (alu_hit && (!mul_hit || (alu_idx < mul_idx))) odr = V_odrf0;
        else if (mul_hit)                                  odr = V_odrf1;
    end

    assign full    = &valid_q;
    assign wb_vld  = (bus.CDI_PC_wb_sel != V_unpip);
    assign pop_en  = ((bus.CDI_PC_selrsv == V_pip0) && (odr == V_odrf0)) ||
                     ((bus.CDI_PC_selrsv == V_pip1) && (odr == V_odrf1));
    assign pop_idx = (bus.CDI_PC_selrsv == V_pip0) ? alu_idx : mul_idx;
    assign push_ok = bus.CFI_PC_valid_in && !full;
    // Valid slots form a prefix, so the first free slot after compaction is count minus pop.
    assign push_idx = W_ent_idx'(cnt - (W_ent_idx + 1)'(pop_en));
    assign rdy1_in  = bus.CDI_PC_rs1_rdy || (bus.CDI_PA_rs1_in == '0) ||
                      (wb_vld && (bus.CDI_PC_wb_rd == bus.CDI_PA_rs1_in));
    assign rdy2_in  = bus.CDI_PC_rs2_rdy || (bus.CDI_PA_rs2_in == '0) ||
                      (wb_vld && (bus.CDI_PC_wb_rd == bus.CDI_PA_rs2_in));

    assign bus.CFO_PC_full  = full;
    assign bus.CDO_PC_odr   = odr;
    assign bus.CDO_PD_uops0 = alu_hit ? uops_q[alu_idx] : unused_op;
    assign bus.CDO_PD_rd0   = alu_hit ? rd_q[alu_idx]   : '0;
    assign bus.CDO_PD_uops1 = mul_hit ? uops_q[mul_idx] : unused_op;
    assign bus.CDO_PD_rd1   = mul_hit ? rd_q[mul_idx]   : '0;

    always_comb begin
        wake1 = '0;
        wake2 = '0;
        for (int i = 0; i < S_amt_ent; i++) begin
            wake1[i] = rdy1_q[i] || (wb_vld && (rs1_q[i] == bus.CDI_PC_wb_rd));
            wake2[i] = rdy2_q[i] || (wb_vld && (rs2_q[i] == bus.CDI_PC_wb_rd));
        end
    end

    // Next state: wakeup, then shift-down compaction on pop, then append push.
    always_comb begin
        valid_d = valid_q;
        rdy1_d  = wake1;
        rdy2_d  = wake2;
        uops_d  = uops_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        if (pop_en) begin
            for (int i = 0; i < S_amt_ent - 1; i++) begin
                if (W_ent_idx'(i) >= pop_idx) begin
                    valid_d[i] = valid_q[i+1];
                    rdy1_d[i]  = wake1[i+1];
                    rdy2_d[i]  = wake2[i+1];
                    uops_d[i]  = uops_q[i+1];
                    rd_d[i]    = rd_q[i+1];
                    rs1_d[i]   = rs1_q[i+1];
                    rs2_d[i]   = rs2_q[i+1];
                end
            end
            valid_d[S_amt_ent-1] = 1'b0;
        end
        if (push_ok) begin
            valid_d[push_idx] = 1'b1;
            rdy1_d[push_idx]  = rdy1_in;
            rdy2_d[push_idx]  = rdy2_in;
            uops_d[push_idx]  = bus.CDI_PD_uops_in;
            rd_d[push_idx]    = bus.CDI_PD_rd_in;
            rs1_d[push_idx]   = bus.CDI_PA_rs1_in;
            rs2_d[push_idx]   = bus.CDI_PA_rs2_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.CFI_PC_clear) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
        end else begin
            valid_q <= valid_d;
            rdy1_q  <= rdy1_d;
            rdy2_q  <= rdy2_d;
            uops_q  <= uops_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
        end
    end

`ifdef RSV_PIP0_OCC_EN
    logic [W_ent_idx:0] occ_q;

    always_ff @(posedge clk) begin
        if (rst || bus.CFI_PC_clear) occ_q <= '0;
        else occ_q <= occ_q + (W_ent_idx + 1)'(push_ok) - (W_ent_idx + 1)'(pop_en);
    end

    assign bus.CDO_PC_occ = occ_q;
`endif
endmodule

// File: tb/tb_rsv_station_pip0.sv
// Scoreboard bench for rsv_station_pip0: driver queues hand-computed per-cycle expectations, monitor checks at negedge.
module tb_rsv_station_pip0;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rsv_station_pip0_if bus ();
    rsv_station_pip0 dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic       rst, clr, vin, r1, r2;
        logic [5:0] uops;
        logic [4:0] rd, rs1, rs2, wbrd;
        logic [1:0] wbs, sel;
    } stim_t;

    typedef struct {
        logic [5:0] u0, u1;
        logic [4:0] rd0, rd1;
        logic [1:0] odr;
        logic       full;
        logic [2:0] occ;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 1'b0, clr: 1'b0, vin: 1'b0, r1: 1'b0, r2: 1'b0, uops: 6'h3f,
              rd: 5'd0, rs1: 5'd0, rs2: 5'd0, wbrd: 5'd0, wbs: 2'b00, sel: 2'b00};
        return s;
    endfunction

    function automatic stim_t sp(input logic [5:0] u, input logic [4:0] d);
        stim_t s;
        s = idle();
        s.vin = 1'b1; s.uops = u; s.rd = d;
        s.rs1 = 5'd1; s.rs2 = 5'd2; s.r1 = 1'b1; s.r2 = 1'b1;
        return s;
    endfunction

    function automatic exp_t ex(input logic [5:0] u0, input logic [4:0] rd0, input logic [5:0] u1,
                                input logic [4:0] rd1, input logic [1:0] odr, input logic full,
                                input logic [2:0] occ);
        exp_t e;
        e = '{u0: u0, u1: u1, rd0: rd0, rd1: rd1, odr: odr, full: full, occ: occ};
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rst                 = s.rst;
        bus.CFI_PC_clear    = s.clr;
        bus.CFI_PC_valid_in = s.vin;
        bus.CDI_PD_uops_in  = s.uops;
        bus.CDI_PD_rd_in    = s.rd;
        bus.CDI_PA_rs1_in   = s.rs1;
        bus.CDI_PA_rs2_in   = s.rs2;
        bus.CDI_PC_rs1_rdy  = s.r1;
        bus.CDI_PC_rs2_rdy  = s.r2;
        bus.CDI_PC_wb_sel   = s.wbs;
        bus.CDI_PC_wb_rd    = s.wbrd;
        bus.CDI_PC_selrsv   = s.sel;
    endtask

    // Queue the expected outputs of the current cycle, then drive inputs for the coming edge.
    task automatic cyc(input stim_t s, input exp_t e);
        exp_q.push_back(e);
        apply(s);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%h req=%h t=%0t", n, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("uops0", 8'(bus.CDO_PD_uops0), 8'(e.u0));
            chk("rd0",   8'(bus.CDO_PD_rd0),   8'(e.rd0));
            chk("uops1", 8'(bus.CDO_PD_uops1), 8'(e.u1));
            chk("rd1",   8'(bus.CDO_PD_rd1),   8'(e.rd1));
            chk("odr",   8'(bus.CDO_PC_odr),   8'(e.odr));
            chk("full",  8'(bus.CFO_PC_full),  8'(e.full));
`ifdef RSV_PIP0_OCC_EN
            chk("occ",   8'(bus.CDO_PC_occ),   8'(e.occ));
`endif
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        exp_t  e0;
        e0 = ex(6'h3f, 5'd0, 6'h3f, 5'd0, 2'b00, 1'b0, 3'd0);
        apply(idle());
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // single ALU push and pop
        s = sp(6'h01, 5'd3);                 cyc(s, e0);
        s = idle(); s.sel = 2'b01;           cyc(s, ex(6'h01, 5'd3, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        // MUL older than ALU
        s = sp(6'h21, 5'd4);                 cyc(s, e0);
        s = sp(6'h02, 5'd5);                 cyc(s, ex(6'h3f, 5'd0, 6'h21, 5'd4, 2'b10, 1'b0, 3'd1));
        s = idle(); s.sel = 2'b10;           cyc(s, ex(6'h02, 5'd5, 6'h21, 5'd4, 2'b10, 1'b0, 3'd2));
        s = idle(); s.sel = 2'b01;           cyc(s, ex(6'h02, 5'd5, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        // writeback wakeup
        s = sp(6'h03, 5'd6); s.rs1 = 5'd7; s.r1 = 1'b0; s.rs2 = 5'd0; s.r2 = 1'b0;
                                             cyc(s, e0);
        s = idle(); s.wbs = 2'b01; s.wbrd = 5'd7;
                                             cyc(s, ex(6'h3f, 5'd0, 6'h3f, 5'd0, 2'b00, 1'b0, 3'd1));
        s = idle(); s.sel = 2'b01;           cyc(s, ex(6'h03, 5'd6, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        // fill, then pop+push while full
        s = sp(6'h11, 5'd1);                 cyc(s, e0);
        s = sp(6'h22, 5'd2);                 cyc(s, ex(6'h11, 5'd1, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        s = sp(6'h12, 5'd3);                 cyc(s, ex(6'h11, 5'd1, 6'h22, 5'd2, 2'b01, 1'b0, 3'd2));
        s = sp(6'h23, 5'd4);                 cyc(s, ex(6'h11, 5'd1, 6'h22, 5'd2, 2'b01, 1'b0, 3'd3));
        s = sp(6'h13, 5'd5); s.sel = 2'b01;  cyc(s, ex(6'h11, 5'd1, 6'h22, 5'd2, 2'b01, 1'b1, 3'd4));
        // selrsv=01 while odr=10 pops nothing
        s = idle(); s.sel = 2'b01;           cyc(s, ex(6'h12, 5'd3, 6'h22, 5'd2, 2'b10, 1'b0, 3'd3));
        // clear with push
        s = sp(6'h14, 5'd6); s.clr = 1'b1;   cyc(s, ex(6'h12, 5'd3, 6'h22, 5'd2, 2'b10, 1'b0, 3'd3));
        s = sp(6'h04, 5'd7);                 cyc(s, e0);
        s = sp(6'h24, 5'd8);                 cyc(s, ex(6'h04, 5'd7, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        // selrsv=10 while odr=01 pops nothing
        s = idle(); s.sel = 2'b10;           cyc(s, ex(6'h04, 5'd7, 6'h24, 5'd8, 2'b01, 1'b0, 3'd2));
        // push+pop when not full
        s = sp(6'h05, 5'd9); s.sel = 2'b01;  cyc(s, ex(6'h04, 5'd7, 6'h24, 5'd8, 2'b01, 1'b0, 3'd2));
        // reset with push
        s = sp(6'h15, 5'd1); s.rst = 1'b1;   cyc(s, ex(6'h05, 5'd9, 6'h24, 5'd8, 2'b10, 1'b0, 3'd2));
        // writeback bypass at dispatch
        s = sp(6'h06, 5'd10); s.rs1 = 5'd9; s.r1 = 1'b0; s.rs2 = 5'd9; s.r2 = 1'b0;
        s.wbs = 2'b10; s.wbrd = 5'd9;        cyc(s, e0);
        s = idle(); s.sel = 2'b01;           cyc(s, ex(6'h06, 5'd10, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        // waiting slot shifts down and wakes in the same cycle
        s = sp(6'h07, 5'd11);                cyc(s, e0);
        s = sp(6'h08, 5'd12); s.rs1 = 5'd13; s.r1 = 1'b0; s.rs2 = 5'd0; s.r2 = 1'b0;
                                             cyc(s, ex(6'h07, 5'd11, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        s = idle(); s.sel = 2'b01; s.wbs = 2'b01; s.wbrd = 5'd13;
                                             cyc(s, ex(6'h07, 5'd11, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd2));
        s = idle(); s.sel = 2'b01;           cyc(s, ex(6'h08, 5'd12, 6'h3f, 5'd0, 2'b01, 1'b0, 3'd1));
        s = idle();                          cyc(s, e0);
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain act=%0d req=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
